muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  XLEN  operand rs1 / dividend.
REQ-007 b  input  XLEN  operand rs2 / divisor.
REQ-008 abort  input  1  cancels the operation in progress.
REQ-009 busy  output  1  high while iterating (CALC).
REQ-010 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 result  output  XLEN  registered result.

Function
REQ-012 FSM states IDLE, CALC, DONE; IDLE->CALC on start; IDLE->DONE on start for a div-by-zero or signed-overflow case; CALC->DONE after XLEN iterations; DONE->IDLE unconditionally.
REQ-013 On an accepted start, a, b and funct3 are latched; later changes to the inputs have no effect.
REQ-014 start outside IDLE is ignored, with no queuing.
REQ-015 Normal latency: start sampled at edge N, busy high for edges N+1..N+XLEN, done high for the cycle after edge N+XLEN+1.
REQ-016 Multiply: radix-2 shift-add on operand magnitudes, 2*XLEN-bit product.
REQ-017 MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
REQ-018 Multiply signedness: a signed for MULH/MULHSU, b signed for MULH only.
REQ-019 Divide: restoring, one quotient bit per cycle on magnitudes.
REQ-020 DIV/REM are signed; quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-021 Sign fix-up is applied on the CALC->DONE edge; it adds no extra cycle.
REQ-022 Divide by zero: quotient all-ones, remainder = a, done one cycle after the start edge.
REQ-023 Signed overflow (a = most-negative, b = -1, DIV/REM): quotient = a, remainder 0, same one-cycle latency.
REQ-024 result holds its value from DONE until the next DONE; it is never cleared by IDLE.
REQ-025 abort in CALC -> IDLE next edge; done is not asserted and result is unchanged.
REQ-026 abort in IDLE or DONE has no effect; abort and start together in IDLE: abort wins, start is dropped.
REQ-027 busy = (state==CALC); done = (state==DONE); both are decoded from the registered state only.

Reset
REQ-028 While reset is high at an edge: state IDLE, busy 0, done 0, result 0, iteration counter 0, latched operands 0.
REQ-029 Reset overrides start and abort in all states, including mid-CALC.
REQ-030 The first start is accepted on the first edge where reset is low.

Structure
REQ-031 Shared package muldiv_pkg holds the funct3 op constants, the state enum and the XLEN-independent op-class helpers (is_div, is_signed_a, is_signed_b).
REQ-032 Single module with no sub-module; one shared XLEN+1-bit adder/subtractor serves both multiply and divide.
REQ-033 The iteration counter is $clog2(XLEN)+1 bits wide.

Verification (XLEN=32)
REQ-034 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 edges after the start edge; busy high for 32 cycles.
REQ-035 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each done one cycle after start, busy never high.
REQ-038 Start MUL 3*4; pulse start with new operands at busy cycle 10 -> ignored, result 12; after completion result stays 12 while idle.
REQ-039 Assert abort at busy cycle 5 (and separately reset at cycle 20) -> IDLE next edge, done never pulses, result keeps its prior value (0 after reset); the next start completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and op-class helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StCalc = 2'd1;
  localparam state_t StDone = 2'd2;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // MUL yields the same low half either way, so it is treated as unsigned.
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3Mulh) || (f3 == F3Mulhsu) || (f3 == F3Div) || (f3 == F3Rem);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3Mulh) || (f3 == F3Div) || (f3 == F3Rem);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: radix-2 shift-add multiply and restoring divide on magnitudes,
// sharing a single XLEN+1-bit adder/subtractor, with sign fix-up on the final iteration.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  state_t            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, hi_q, lo_q, result_q;
  logic [CntW-1:0]   cnt_q;

  // Operand magnitudes for the latched operation.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  assign a_neg = is_signed_a(op_q) & a_q[XLEN-1];
  assign b_neg = is_signed_b(op_q) & b_q[XLEN-1];
  assign mag_a = a_neg ? -a_q : a_q;
  assign mag_b = b_neg ? -b_q : b_q;

  // Values needed when accepting a new request.
  logic            in_a_neg, in_b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] in_mag_a, in_mag_b, special_res;
  assign in_a_neg = is_signed_a(funct3) & a[XLEN-1];
  assign in_b_neg = is_signed_b(funct3) & b[XLEN-1];
  assign in_mag_a = in_a_neg ? -a : a;
  assign in_mag_b = in_b_neg ? -b : b;
  assign div_zero = is_div(funct3) && (b == '0);
  assign div_ovf  = is_div(funct3) && is_signed_b(funct3) && (b == '1) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}});
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : a;
  end

  // The one shared adder/subtractor.
  logic [XLEN:0] add_a, add_b, sum;
  logic          add_sub;
  always_comb begin
    if (is_div(op_q)) begin
      add_a   = {hi_q, lo_q[XLEN-1]};
      add_b   = {1'b0, mag_b};
      add_sub = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = {1'b0, mag_a};
      add_sub = 1'b0;
    end
    sum = add_sub ? (add_a - add_b) : (add_a + add_b);
  end

  // One iteration step; sum[XLEN] set on a divide means the trial subtraction underflowed.
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [XLEN:0]   part;
  always_comb begin
    part = lo_q[0] ? sum : {1'b0, hi_q};
    if (is_div(op_q)) begin
      if (!sum[XLEN]) hi_nxt = sum[XLEN-1:0];
      else            hi_nxt = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      lo_nxt = {lo_q[XLEN-2:0], ~sum[XLEN]};
    end else begin
      hi_nxt = part[XLEN:1];
      lo_nxt = {part[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the final step's values.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, rem, fix_res;
  always_comb begin
    prod   = {hi_nxt, lo_nxt};
    prod_s = (a_neg ^ b_neg) ? -prod : prod;
    quot   = (a_neg ^ b_neg) ? -lo_nxt : lo_nxt;
    rem    = a_neg ? -hi_nxt : hi_nxt;
    if (is_div(op_q))        fix_res = op_q[1] ? rem : quot;
    else if (op_q == F3Mul)  fix_res = prod_s[XLEN-1:0];
    else                     fix_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            op_q  <= funct3;
            a_q   <= a;
            b_q   <= b;
            hi_q  <= '0;
            lo_q  <= is_div(funct3) ? in_mag_a : in_mag_b;
            cnt_q <= '0;
            if (special) begin
              result_q <= special_res;
              state_q  <= StDone;
            end else begin
              state_q  <= StCalc;
            end
          end
        end
        StCalc: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(XLEN - 1)) begin
              result_q <= fix_res;
              state_q  <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q == StCalc);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, abort, busy, done;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Launches one op, scrambles inputs afterwards, returns the result, the number of edges
  // from the start edge to the edge that samples done (-1 on timeout) and busy cycles seen.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] oa, input logic [31:0] ob,
                       output logic [31:0] res, output int edges, output int bcyc);
    funct3 = f3; a = oa; b = ob; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; funct3 = ~f3;
    edges = -1; bcyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) bcyc++;
      if (done) begin
        edges = i + 1;
        break;
      end
      @(posedge clk); #1;
    end
    res = result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] res; int e, bc;
    reset = 1'b1; start = 1'b1; abort = 1'b0; funct3 = F3Mul; a = 32'd2; b = 32'd3;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    // start held through reset release is taken on the first free edge
    reset = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got %b want 1", busy); end
    e = -1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin e = i; break; end
      @(posedge clk); #1;
    end
    checks++; if (result !== 32'd6) begin errors++; $display("FAIL first_start_result got %h want 6", result); end
    @(posedge clk); #1;
    do_op(F3Mul, 32'd0, 32'd0, res, e, bc);
  endtask

  task automatic test_mul();
    logic [31:0] res; int e, bc;
    do_op(F3Mul, 32'd7, 32'hFFFF_FFFD, res, e, bc);
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", res); end
    checks++; if (e !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", e); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", bc); end
  endtask

  task automatic test_mulh();
    logic [31:0] res; int e, bc;
    do_op(F3Mulh, 32'h8000_0000, 32'h8000_0000, res, e, bc);
    checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulh got %h want 40000000", res); end
    do_op(F3Mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, e, bc);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", res); end
    do_op(F3Mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, e, bc);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", res); end
  endtask

  task automatic test_div();
    logic [31:0] res; int e, bc;
    do_op(F3Div, 32'hFFFF_FFF9, 32'd2, res, e, bc);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div got %h want fffffffd", res); end
    checks++; if (e !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", e); end
    do_op(F3Rem, 32'hFFFF_FFF9, 32'd2, res, e, bc);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem got %h want ffffffff", res); end
    do_op(F3Divu, 32'd100, 32'd7, res, e, bc);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu got %h want e", res); end
    do_op(F3Remu, 32'd100, 32'd7, res, e, bc);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu got %h want 2", res); end
  endtask

  task automatic test_special();
    logic [31:0] res; int e, bc;
    do_op(F3Divu, 32'd5, 32'd0, res, e, bc);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero got %h want ffffffff", res); end
    checks++; if (e !== 1 || bc !== 0) begin errors++; $display("FAIL divu_zero_timing got edges=%0d busy=%0d want 1/0", e, bc); end
    do_op(F3Remu, 32'd5, 32'd0, res, e, bc);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu_zero got %h want 5", res); end
    checks++; if (e !== 1 || bc !== 0) begin errors++; $display("FAIL remu_zero_timing got edges=%0d busy=%0d want 1/0", e, bc); end
    do_op(F3Div, 32'h8000_0000, 32'hFFFF_FFFF, res, e, bc);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h want 80000000", res); end
    checks++; if (e !== 1 || bc !== 0) begin errors++; $display("FAIL div_ovf_timing got edges=%0d busy=%0d want 1/0", e, bc); end
    do_op(F3Rem, 32'h8000_0000, 32'hFFFF_FFFF, res, e, bc);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL rem_ovf got %h want 0", res); end
    checks++; if (e !== 1 || bc !== 0) begin errors++; $display("FAIL rem_ovf_timing got edges=%0d busy=%0d want 1/0", e, bc); end
  endtask

  task automatic test_ignore_start();
    int obs, done_obs, done_seen;
    funct3 = F3Mul; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obs = 1;
    repeat (9) begin @(posedge clk); #1; obs++; end
    funct3 = F3Mulhu; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; obs++;
    start = 1'b0;
    done_obs = -1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin done_obs = obs; break; end
      @(posedge clk); #1; obs++;
    end
    checks++; if (done_obs !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", done_obs); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL ignore_result got %h want c", result); end
    done_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (done) done_seen++; end
    checks++; if (result !== 32'd12 || done_seen !== 1'b0) begin
      errors++; $display("FAIL idle_hold got result=%h dones=%0d want c/0", result, done_seen);
    end
  endtask

  task automatic test_abort();
    logic [31:0] res; int e, bc, done_seen;
    funct3 = F3Divu; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b want 1", busy); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    done_seen = 0;
    repeat (40) begin if (done) done_seen++; @(posedge clk); #1; end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", done_seen); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL abort_result got %h want c", result); end
    do_op(F3Remu, 32'd100, 32'd7, res, e, bc);
    checks++; if (res !== 32'd2 || e !== 33) begin
      errors++; $display("FAIL after_abort got %h edges=%0d want 2/33", res, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int e, bc, done_seen;
    funct3 = F3Mul; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state got busy=%b done=%b want 0/0", busy, done);
    end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL mid_reset_result got %h want 0", result); end
    done_seen = 0;
    repeat (40) begin if (done) done_seen++; @(posedge clk); #1; end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL mid_reset_done got %0d pulses want 0", done_seen); end
    do_op(F3Divu, 32'd100, 32'd7, res, e, bc);
    checks++; if (res !== 32'd14 || e !== 33) begin
      errors++; $display("FAIL after_reset got %h edges=%0d want e/33", res, e);
    end
  endtask

  task automatic test_abort_start_idle();
    funct3 = F3Mul; a = 32'd5; b = 32'd5; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_start got busy=%b done=%b want 0/0", busy, done);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || result !== 32'd14) begin
      errors++; $display("FAIL abort_start_hold got done=%b result=%h want 0/e", done, result);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_ignore_start();
    test_abort();
    test_reset_mid();
    test_abort_start_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
